// File: rtl/acc_chk_pkg.sv
// acc_chk_pkg
//   Shared types and constants for the acc_core receive-side stream checker.
//   - chk_state_e : checker state encoding (IDLE, PRIME, RUN, PASS, FAIL)
//   - CHK_DATA_W  : default stream word width
//   - LFSR_TAPS   : feedback mask of the 16-bit backpressure LFSR
//   - lfsr_step() : one shift of that LFSR
package acc_chk_pkg;

  localparam int unsigned CHK_DATA_W = 128;

  // Fibonacci taps 16,14,13,11 expressed on a right-shifting register:
  // tap n corresponds to state bit (16-n), i.e. bits 0, 2, 3 and 5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    RUN   = 3'd2,
    PASS  = 3'd3,
    FAIL  = 3'd4
  } chk_state_e;

  // Shift right; the XOR of the tapped bits enters at the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/acc_stream_checker_if.sv
// acc_stream_checker_if
//   AXI-Stream style word channel between acc_core's outa port and the checker.
//   Signals : s_tdata (DATA_W), s_tvalid, s_tready
//   master  : drives s_tdata/s_tvalid, receives s_tready (stream source)
//   slave   : receives s_tdata/s_tvalid, drives s_tready (the checker)
interface acc_stream_checker_if
  import acc_chk_pkg::*;
#(
  parameter int unsigned DATA_W = CHK_DATA_W
);

  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tready;

  modport master (output s_tdata, output s_tvalid, input s_tready);
  modport slave  (input s_tdata, input s_tvalid, output s_tready);

endinterface

// File: rtl/chk_lfsr16.sv
// chk_lfsr16
//   16-bit Fibonacci LFSR (taps 16,14,13,11) used to generate backpressure.
//   Ports:
//     clk_core   in   clock
//     rst_core_n in   synchronous active-low reset (loads SEED)
//     load_i     in   reload SEED (has priority over en_i)
//     en_i       in   advance one step
//     state_o    out  current LFSR state
//     next_o     out  value the LFSR will hold after this clock edge
module chk_lfsr16
  import acc_chk_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_core,
  input  logic        rst_core_n,
  input  logic        load_i,
  input  logic        en_i,
  output logic [15:0] state_o,
  output logic [15:0] next_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (en_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk_core) begin
    if (!rst_core_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;
  assign next_o  = lfsr_d;

endmodule

// File: rtl/acc_stream_checker.sv
// acc_stream_checker
//   Receive-side self-test harness for the 128-bit outa stream of acc_core.
//   Accepts beats with LFSR or constant backpressure, compares each accepted
//   beat with a word read from an external synchronous expected-data ROM and
//   reports pass/fail, error count, first mismatch index and watchdog timeout.
//
//   Build option: define CHK_STOP_ON_ERR_EN to end the run (FAIL) on the
//   first mismatching beat; by default every beat of the run is checked.
//
//   Ports:
//     clk_core      in   sole clock
//     rst_core_n    in   synchronous active-low reset
//     start         in   pulse; begins a run from IDLE/PASS/FAIL
//     num_words     in   beats to check (0 = immediate PASS), sampled on start
//     thru_mode     in   1: tready held high in RUN, 0: LFSR backpressure
//     s_if          slave stream (s_tdata, s_tvalid in; s_tready out)
//     exp_addr      out  ROM read address (lookahead)
//     exp_data      in   ROM data, one-cycle registered read of exp_addr
//     busy          out  PRIME or RUN
//     done          out  PASS or FAIL
//     pass          out  PASS
//     timeout       out  sticky watchdog flag
//     err_cnt       out  mismatching beats in this run
//     first_err_idx out  index of first mismatch (valid when err_cnt != 0)
//     word_cnt      out  beats accepted in this run
module acc_stream_checker
  import acc_chk_pkg::*;
#(
  parameter int unsigned DATA_W    = CHK_DATA_W,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic                 clk_core,
  input  logic                 rst_core_n,
  input  logic                 start,
  input  logic [ADDR_W:0]      num_words,
  input  logic                 thru_mode,
  acc_stream_checker_if.slave  s_if,
  output logic [ADDR_W-1:0]    exp_addr,
  input  logic [DATA_W-1:0]    exp_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [ADDR_W:0]      err_cnt,
  output logic [ADDR_W-1:0]    first_err_idx,
  output logic [ADDR_W:0]      word_cnt
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  chk_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] first_err_idx_q, first_err_idx_d;
  logic              timeout_q, timeout_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [CNT_W-1:0]  num_words_q, num_words_d;
  logic              thru_q, thru_d;
  logic              tready_q, tready_d;

  logic              lfsr_load;
  logic              lfsr_en;
  logic [15:0]       lfsr_state;
  logic [15:0]       lfsr_next;
  logic              unused_lfsr;

  logic              accept;
  logic              mismatch;

  chk_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .load_i     (lfsr_load),
    .en_i       (lfsr_en),
    .state_o    (lfsr_state),
    .next_o     (lfsr_next)
  );

  // Only the low two bits of the upcoming LFSR value steer readiness.
  assign unused_lfsr = ^{lfsr_state, lfsr_next[15:2]};

  assign accept = (state_q == RUN) && s_if.s_tvalid && tready_q;
  // Case inequality so that X/Z on the stream is reported as a mismatch.
  assign mismatch = (s_if.s_tdata !== exp_data);

  // State register
  always_ff @(posedge clk_core) begin
    if (!rst_core_n) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      word_cnt_q      <= '0;
      err_cnt_q       <= '0;
      first_err_idx_q <= '0;
      timeout_q       <= 1'b0;
      wd_q            <= '0;
      num_words_q     <= '0;
      thru_q          <= 1'b0;
      tready_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      word_cnt_q      <= word_cnt_d;
      err_cnt_q       <= err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
      timeout_q       <= timeout_d;
      wd_q            <= wd_d;
      num_words_q     <= num_words_d;
      thru_q          <= thru_d;
      tready_q        <= tready_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    word_cnt_d      = word_cnt_q;
    err_cnt_d       = err_cnt_q;
    first_err_idx_d = first_err_idx_q;
    timeout_d       = timeout_q;
    wd_d            = wd_q;
    num_words_d     = num_words_q;
    thru_d          = thru_q;
    lfsr_load       = 1'b0;
    lfsr_en         = 1'b0;

    case (state_q)
      IDLE, PASS, FAIL: begin
        if (start) begin
          idx_d           = '0;
          word_cnt_d      = '0;
          err_cnt_d       = '0;
          first_err_idx_d = '0;
          timeout_d       = 1'b0;
          wd_d            = '0;
          num_words_d     = num_words;
          thru_d          = thru_mode;
          lfsr_load       = 1'b1;
          state_d         = (num_words == '0) ? PASS : PRIME;
        end
      end

      // One dead cycle so the ROM word for index 0 is on exp_data in RUN.
      PRIME: begin
        state_d = RUN;
      end

      RUN: begin
        lfsr_en = 1'b1;
        if (accept) begin
          wd_d       = '0;
          idx_d      = idx_q + ADDR_W'(1);
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (mismatch) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
            if (err_cnt_q == '0) begin
              first_err_idx_d = idx_q;
            end
          end
          if (word_cnt_d == num_words_q) begin
            state_d = (err_cnt_d == '0) ? PASS : FAIL;
          end
`ifdef CHK_STOP_ON_ERR_EN
          if (mismatch) begin
            state_d = FAIL;
          end
`endif
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_d   = FAIL;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Readiness is registered: decided from the state and LFSR value the
    // next cycle will hold, so s_tready never depends on s_tvalid.
    tready_d = (state_d == RUN) && (thru_d || (lfsr_next[1:0] != 2'b00));
  end

  // Outputs
  always_comb begin
    busy          = (state_q == PRIME) || (state_q == RUN);
    done          = (state_q == PASS) || (state_q == FAIL);
    pass          = (state_q == PASS);
    timeout       = timeout_q;
    err_cnt       = err_cnt_q;
    first_err_idx = first_err_idx_q;
    word_cnt      = word_cnt_q;
    // Lookahead address: fetch the next word as soon as the current one is
    // consumed so a beat can be checked every cycle.
    exp_addr      = accept ? (idx_q + ADDR_W'(1)) : idx_q;
  end

  assign s_if.s_tready = tready_q;

endmodule

// File: tb/tb_acc_stream_checker.sv
// tb_acc_stream_checker
//   Directed self-checking bench for acc_stream_checker: constant and LFSR
//   backpressure runs, a corrupted beat, watchdog expiry and mid-run reset.
//   Expected results follow CHK_STOP_ON_ERR_EN when it is defined.
module tb_acc_stream_checker;

  localparam int DATA_W  = 128;
  localparam int DEPTH   = 128;
  localparam int ADDR_W  = 7;
  localparam int TIMEOUT = 4096;

  logic              clk_core = 1'b0;
  logic              rst_core_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   num_words = '0;
  logic              thru_mode = 1'b0;
  logic              tvalid = 1'b0;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              busy, done, pass, timeout;
  logic [ADDR_W:0]   err_cnt, word_cnt;
  logic [ADDR_W-1:0] first_err_idx;

  logic [DATA_W-1:0] rom [0:DEPTH-1];
  logic [DATA_W-1:0] src [0:DEPTH-1];
  int                hs_cnt = 0;

  int pass_cnt = 0;
  int total_cnt = 0;

  acc_stream_checker_if #(.DATA_W(DATA_W)) s_if ();

  acc_stream_checker #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_core      (clk_core),
    .rst_core_n    (rst_core_n),
    .start         (start),
    .num_words     (num_words),
    .thru_mode     (thru_mode),
    .s_if          (s_if),
    .exp_addr      (exp_addr),
    .exp_data      (exp_data),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .err_cnt       (err_cnt),
    .first_err_idx (first_err_idx),
    .word_cnt      (word_cnt)
  );

  always #5 clk_core = ~clk_core;

  // Synchronous expected-data ROM
  always @(posedge clk_core) exp_data <= rom[exp_addr];

  // Stream source: present src[hs_cnt], advance on each handshake
  assign s_if.s_tvalid = tvalid;
  assign s_if.s_tdata  = src[hs_cnt[ADDR_W-1:0]];

  always @(posedge clk_core) begin
    if (start) begin
      hs_cnt <= 0;
    end else if (s_if.s_tvalid && s_if.s_tready) begin
      $display("beat %0d accepted data=%h", hs_cnt, s_if.s_tdata);
      hs_cnt <= hs_cnt + 1;
    end
  end

  task automatic fill_data();
    for (int i = 0; i < DEPTH; i++) begin
      for (int b = 0; b < 16; b++) begin
        rom[i][8*b +: 8] = 8'(16*i + b);
      end
      src[i] = rom[i];
    end
  endtask

  task automatic start_run(input logic [ADDR_W:0] n, input logic thru);
    @(negedge clk_core);
    num_words = n;
    thru_mode = thru;
    start = 1'b1;
    @(negedge clk_core);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk_core);
      cyc++;
    end while (!done && cyc < budget);
  endtask

  task automatic test_reset();
    rst_core_n = 1'b0;
    repeat (2) @(negedge clk_core);
    rst_core_n = 1'b1;
    total_cnt++; if (s_if.s_tready !== 1'b0) $display("FAIL rst_tready: got %b expected 0", s_if.s_tready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else pass_cnt++;
    total_cnt++; if (pass !== 1'b0) $display("FAIL rst_pass: got %b expected 0", pass); else pass_cnt++;
    total_cnt++; if (timeout !== 1'b0) $display("FAIL rst_timeout: got %b expected 0", timeout); else pass_cnt++;
    total_cnt++; if (err_cnt !== '0) $display("FAIL rst_err_cnt: got %0d expected 0", err_cnt); else pass_cnt++;
    total_cnt++; if (word_cnt !== '0) $display("FAIL rst_word_cnt: got %0d expected 0", word_cnt); else pass_cnt++;
    total_cnt++; if (exp_addr !== '0) $display("FAIL rst_exp_addr: got %0d expected 0", exp_addr); else pass_cnt++;
    $display("test_reset complete");
  endtask

  task automatic test_thru();
    int cyc;
    fill_data();
    tvalid = 1'b1;
    start_run(8'd4, 1'b1);
    // now in PRIME
    total_cnt++; if (busy !== 1'b1) $display("FAIL thru_prime_busy: got %b expected 1", busy); else pass_cnt++;
    total_cnt++; if (s_if.s_tready !== 1'b0) $display("FAIL thru_prime_tready: got %b expected 0", s_if.s_tready); else pass_cnt++;
    wait_done(50, cyc);
    total_cnt++; if (cyc !== 5) $display("FAIL thru_latency: got %0d expected 5", cyc); else pass_cnt++;
    total_cnt++; if (pass !== 1'b1) $display("FAIL thru_pass: got %b expected 1", pass); else pass_cnt++;
    total_cnt++; if (err_cnt !== '0) $display("FAIL thru_err_cnt: got %0d expected 0", err_cnt); else pass_cnt++;
    total_cnt++; if (word_cnt !== 8'd4) $display("FAIL thru_word_cnt: got %0d expected 4", word_cnt); else pass_cnt++;
    total_cnt++; if (hs_cnt !== 4) $display("FAIL thru_handshakes: got %0d expected 4", hs_cnt); else pass_cnt++;
    total_cnt++; if (s_if.s_tready !== 1'b0) $display("FAIL thru_tready_after: got %b expected 0", s_if.s_tready); else pass_cnt++;
    $display("test_thru complete");
  endtask

  task automatic test_lfsr();
    logic [15:0] model;
    logic [4:0]  first5;
    int          run_cyc;
    int          bad;
    int          cyc;
    fill_data();
    tvalid = 1'b1;
    start_run(8'd128, 1'b0);
    model = 16'hACE1;
    first5 = '0;
    run_cyc = 0;
    bad = 0;
    cyc = 0;
    while (cyc < 1000) begin
      @(negedge clk_core);
      cyc++;
      if (done) break;
      if (s_if.s_tready !== (model[1:0] != 2'b00)) bad++;
      if (run_cyc < 5) first5 = {first5[3:0], s_if.s_tready};
      run_cyc++;
      model = {model[0] ^ model[2] ^ model[3] ^ model[5], model[15:1]};
    end
    total_cnt++; if (done !== 1'b1) $display("FAIL lfsr_done: got %b expected 1 after %0d cycles", done, cyc); else pass_cnt++;
    total_cnt++; if (first5 !== 5'b10001) $display("FAIL lfsr_first5: got %b expected 10001", first5); else pass_cnt++;
    total_cnt++; if (bad !== 0) $display("FAIL lfsr_pattern: got %0d wrong cycles expected 0", bad); else pass_cnt++;
    total_cnt++; if (pass !== 1'b1) $display("FAIL lfsr_pass: got %b expected 1", pass); else pass_cnt++;
    total_cnt++; if (word_cnt !== 8'd128) $display("FAIL lfsr_word_cnt: got %0d expected 128", word_cnt); else pass_cnt++;
    total_cnt++; if (hs_cnt !== 128) $display("FAIL lfsr_handshakes: got %0d expected 128", hs_cnt); else pass_cnt++;
    total_cnt++; if (err_cnt !== '0) $display("FAIL lfsr_err_cnt: got %0d expected 0", err_cnt); else pass_cnt++;
    $display("test_lfsr complete, %0d run cycles", run_cyc);
  endtask

  task automatic test_error();
    int cyc;
    fill_data();
    src[3][0] = ~src[3][0];
    tvalid = 1'b1;
    start_run(8'd8, 1'b1);
    wait_done(50, cyc);
    total_cnt++; if (done !== 1'b1 || pass !== 1'b0) $display("FAIL err_state: got done=%b pass=%b expected done=1 pass=0", done, pass); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd1) $display("FAIL err_err_cnt: got %0d expected 1", err_cnt); else pass_cnt++;
    total_cnt++; if (first_err_idx !== 7'd3) $display("FAIL err_first_idx: got %0d expected 3", first_err_idx); else pass_cnt++;
    total_cnt++; if (timeout !== 1'b0) $display("FAIL err_timeout: got %b expected 0", timeout); else pass_cnt++;
`ifdef CHK_STOP_ON_ERR_EN
    total_cnt++; if (cyc !== 5) $display("FAIL err_latency: got %0d expected 5", cyc); else pass_cnt++;
    repeat (4) @(negedge clk_core);
    total_cnt++; if (word_cnt !== 8'd4) $display("FAIL err_word_cnt: got %0d expected 4", word_cnt); else pass_cnt++;
    total_cnt++; if (hs_cnt !== 4) $display("FAIL err_handshakes: got %0d expected 4", hs_cnt); else pass_cnt++;
    total_cnt++; if (s_if.s_tready !== 1'b0) $display("FAIL err_tready: got %b expected 0", s_if.s_tready); else pass_cnt++;
`else
    total_cnt++; if (cyc !== 9) $display("FAIL err_latency: got %0d expected 9", cyc); else pass_cnt++;
    total_cnt++; if (word_cnt !== 8'd8) $display("FAIL err_word_cnt: got %0d expected 8", word_cnt); else pass_cnt++;
    total_cnt++; if (hs_cnt !== 8) $display("FAIL err_handshakes: got %0d expected 8", hs_cnt); else pass_cnt++;
`endif
    $display("test_error complete");
  endtask

  task automatic test_timeout();
    int cyc;
    fill_data();
    tvalid = 1'b0;
    start_run(8'd2, 1'b1);
    wait_done(TIMEOUT + 200, cyc);
    // RUN starts one cycle after PRIME; FAIL shows TIMEOUT cycles later
    total_cnt++; if (cyc !== TIMEOUT + 1) $display("FAIL to_latency: got %0d expected %0d", cyc, TIMEOUT + 1); else pass_cnt++;
    total_cnt++; if (timeout !== 1'b1) $display("FAIL to_flag: got %b expected 1", timeout); else pass_cnt++;
    total_cnt++; if (done !== 1'b1 || pass !== 1'b0) $display("FAIL to_state: got done=%b pass=%b expected done=1 pass=0", done, pass); else pass_cnt++;
    total_cnt++; if (word_cnt !== '0) $display("FAIL to_word_cnt: got %0d expected 0", word_cnt); else pass_cnt++;
    $display("test_timeout complete");
  endtask

  task automatic test_midrun_reset();
    int cyc;
    fill_data();
    tvalid = 1'b1;
    start_run(8'd20, 1'b1);
    cyc = 0;
    while (word_cnt !== 8'd5 && cyc < 50) begin
      @(negedge clk_core);
      cyc++;
    end
    total_cnt++; if (word_cnt !== 8'd5) $display("FAIL mr_reach5: got %0d expected 5", word_cnt); else pass_cnt++;
    rst_core_n = 1'b0;
    @(negedge clk_core);
    rst_core_n = 1'b1;
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) $display("FAIL mr_status: got busy=%b done=%b pass=%b expected 000", busy, done, pass); else pass_cnt++;
    total_cnt++; if (word_cnt !== '0) $display("FAIL mr_word_cnt: got %0d expected 0", word_cnt); else pass_cnt++;
    total_cnt++; if (s_if.s_tready !== 1'b0) $display("FAIL mr_tready: got %b expected 0", s_if.s_tready); else pass_cnt++;
    total_cnt++; if (exp_addr !== '0) $display("FAIL mr_exp_addr: got %0d expected 0", exp_addr); else pass_cnt++;
    start_run(8'd0, 1'b1);
    total_cnt++; if (pass !== 1'b1 || done !== 1'b1) $display("FAIL mr_zero_pass: got pass=%b done=%b expected 11", pass, done); else pass_cnt++;
    total_cnt++; if (word_cnt !== '0) $display("FAIL mr_zero_word_cnt: got %0d expected 0", word_cnt); else pass_cnt++;
    $display("test_midrun_reset complete");
  endtask

  initial begin
    fill_data();
    test_reset();
    test_thru();
    test_lfsr();
    test_error();
    test_timeout();
    test_midrun_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/acc_stream_checker.md
Name: acc_stream_checker

Overview:
- Synthesizable receive-side harness for the 128-bit output stream of acc_core.
- Sinks outa_tdata/outa_tvalid and drives outa_tready, using LFSR-generated or constant backpressure.
- Compares every accepted beat against a word from an external synchronous expected-data ROM.
- Reports pass/fail, error count, first mismatch index, and watchdog timeout.
- Used in on-chip self-test alongside the input stream source.

Parameters:
- DATA_W, 128, stream word width.
- DEPTH, 128, maximum words per run; ROM depth.
- ADDR_W, $clog2(DEPTH), ROM address width.
- LFSR_SEED, 16'hACE1, reset/start value of the backpressure LFSR; must be nonzero.
- TIMEOUT, 4096, idle cycles without an accepted beat before a RUN is declared failed.

Ports:
- clk_core  in  1  sole clock.
- rst_core_n  in  1  synchronous, active-low reset.
- start  in  1  pulse; begins a run when in IDLE, PASS or FAIL.
- num_words  in  ADDR_W+1  beats to check; sampled on start; 0 means immediate PASS.
- thru_mode  in  1  1: tready constant 1 during RUN; 0: LFSR backpressure. Sampled on start.
- s_tdata  in  DATA_W  stream data from acc_core outa.
- s_tvalid  in  1  stream valid.
- s_tready  out  1  stream ready.
- exp_addr  out  ADDR_W  ROM read address.
- exp_data  in  DATA_W  ROM data; one-cycle registered read of exp_addr.
- busy  out  1  high in PRIME/RUN.
- done  out  1  high in PASS or FAIL.
- pass  out  1  high in PASS only.
- timeout  out  1  sticky; set when the watchdog fires.
- err_cnt  out  ADDR_W+1  mismatching beats in the current run.
- first_err_idx  out  ADDR_W  index of the first mismatch; valid when err_cnt != 0.
- word_cnt  out  ADDR_W+1  beats accepted in the current run.

Behaviour:
- Reset (rst_core_n=0 at posedge): state IDLE.
  - s_tready=0, busy=0, done=0, pass=0, timeout=0, err_cnt=0, first_err_idx=0, word_cnt=0.
  - exp_addr=0, LFSR=LFSR_SEED.
  - Reset mid-run aborts immediately; no partial status is retained.
- States: IDLE, PRIME, RUN, PASS, FAIL.
- IDLE/PASS/FAIL with start=1:
  - If num_words==0: go to PASS.
  - Otherwise go to PRIME; clear counters and timeout; LFSR=LFSR_SEED; idx=0; exp_addr=0.
- start outside IDLE/PASS/FAIL is ignored.
- PRIME: exactly one cycle, s_tready=0, so ROM data for idx 0 is present. Then go to RUN.
- RUN readiness:
  - thru_mode=1: s_tready=1.
  - thru_mode=0: s_tready = (lfsr[1:0] != 0), about 75% duty.
  - s_tready is registered. It does not depend combinationally on s_tvalid.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every RUN cycle regardless of handshake.
- Accept = s_tvalid & s_tready in RUN.
  - Compare s_tdata against exp_data with 4-state equality; X/Z on s_tdata counts as a mismatch.
- exp_addr = accept ? idx+1 : idx (combinational lookahead). Exp data for idx is therefore valid every RUN cycle, giving full throughput of one beat per cycle.
- On accept:
  - word_cnt++, idx++.
  - On mismatch: err_cnt++. If err_cnt was 0, first_err_idx=idx.
  - If word_cnt+1 == num_words: next state is PASS when total errors = 0, else FAIL. s_tready drops the following cycle.
- Watchdog: counter clears on accept and increments in RUN otherwise.
  - On reaching TIMEOUT-1 without accept: FAIL, timeout=1.
- PASS/FAIL hold until start or reset; s_tready=0. Beats presented there are not consumed.
- Width rules:
  - Counters cannot overflow because num_words <= DEPTH.
  - idx wraps at 2^ADDR_W only after the final beat, which is never used.

Optional Feature:
- Macro: CHK_STOP_ON_ERR_EN.
- Defined: the first mismatching accept moves RUN -> FAIL on the next cycle. err_cnt=1, s_tready deasserts, and remaining beats are not consumed.
- Undefined: checking continues to num_words and all mismatches are counted. Final state is PASS iff err_cnt==0.

Decomposition:
- Package acc_chk_pkg holds:
  - typedef enum logic [2:0] chk_state_e {IDLE, PRIME, RUN, PASS, FAIL}.
  - localparam LFSR_TAPS.
  - the DATA_W default.
- Sub-module chk_lfsr16 (seed load, enable, 16-bit state out) is instantiated once.

Test Plan:
- thru_mode=1, num_words=4, ROM=stream=0x00..0F, 0x10..1F, ...; tvalid constant 1 -> 4 accepts on consecutive cycles after PRIME; PASS, err_cnt=0, word_cnt=4.
- thru_mode=0, num_words=128, matching data -> s_tready follows LFSR pattern from LFSR_SEED; PASS after 128 accepts; no accepted beat is dropped or duplicated.
- num_words=8, beat 3 corrupted (bit 0 flipped), macro undefined -> FAIL, err_cnt=1, first_err_idx=3, word_cnt=8.
- Same stimulus with CHK_STOP_ON_ERR_EN defined -> FAIL one cycle after beat 3; word_cnt=4, s_tready=0 afterwards.
- num_words=2, tvalid held 0 -> FAIL and timeout=1 exactly TIMEOUT cycles after entering RUN.
- rst_core_n low for one cycle mid-run after 5 beats -> all outputs at reset values; a new start with num_words=0 gives PASS next cycle.
